// File: rtl/cam_cfg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cam_cfg_sequencer: walks a camera register-init table in a registered ROM   |
// | and feeds each {reg, value} word to the i2c write engine. Optional macro:   |
// | CAM_CFG_DELAY_EN builds the in-table delay-marker wait.                     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module cam_cfg_sequencer #(
   parameter int          ADDR_W       = 8,
   parameter int          DELAY_CYCLES = 100_000,
   parameter logic [15:0] END_WORD     = 16'hFFFF,
   parameter logic [15:0] DELAY_WORD   = 16'hFFF0
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [15:0]       rom_data_i,
   output logic [15:0]       write_data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              busy_o,
   output logic              done_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_SEND   = 3'd3,
      S_DELAY  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   if (DELAY_CYCLES < 1) begin : g_bad_delay_cycles
      $error("DELAY_CYCLES must be at least 1");
   end

   state_t            state_q;
   logic [ADDR_W-1:0] rom_addr_q;
   logic [15:0]       write_data_q;
   logic              valid_q;
   logic              busy_q;
   logic              done_q;

`ifdef CAM_CFG_DELAY_EN
   localparam int              CNT_W    = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY_CYCLES - 1);
   logic [CNT_W-1:0] delay_cnt_q;
`endif

   // Shared "move past this entry" step: the table never wraps past its last address.
   state_t            adv_state_d;
   logic [ADDR_W-1:0] adv_addr_d;
   logic              adv_last_d;

   always_comb begin
      adv_last_d  = (rom_addr_q == {ADDR_W{1'b1}});
      adv_state_d = adv_last_d ? S_DONE : S_FETCH;
      adv_addr_d  = adv_last_d ? rom_addr_q : rom_addr_q + ADDR_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= S_IDLE;
         rom_addr_q   <= '0;
         write_data_q <= '0;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
`ifdef CAM_CFG_DELAY_EN
         delay_cnt_q  <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  rom_addr_q <= '0;
                  state_q    <= S_FETCH;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
               end
            end
            S_FETCH: state_q <= S_DECODE;
            S_DECODE: begin
               if (rom_data_i == END_WORD) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else if (rom_data_i == DELAY_WORD) begin
`ifdef CAM_CFG_DELAY_EN
                  state_q     <= S_DELAY;
                  delay_cnt_q <= CNT_LOAD;
`else
                  state_q    <= adv_state_d;
                  rom_addr_q <= adv_addr_d;
                  busy_q     <= !adv_last_d;
                  done_q     <= adv_last_d;
`endif
               end else begin
                  write_data_q <= rom_data_i;
                  valid_q      <= 1'b1;
                  state_q      <= S_SEND;
               end
            end
            S_SEND: begin
               if (ready_i) begin
                  valid_q    <= 1'b0;
                  state_q    <= adv_state_d;
                  rom_addr_q <= adv_addr_d;
                  busy_q     <= !adv_last_d;
                  done_q     <= adv_last_d;
               end
            end
`ifdef CAM_CFG_DELAY_EN
            S_DELAY: begin
               if (delay_cnt_q == '0) begin
                  state_q    <= adv_state_d;
                  rom_addr_q <= adv_addr_d;
                  busy_q     <= !adv_last_d;
                  done_q     <= adv_last_d;
               end else begin
                  delay_cnt_q <= delay_cnt_q - CNT_W'(1);
               end
            end
`endif
            default: begin
               state_q <= S_IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rom_addr_o   = rom_addr_q;
   assign write_data_o = write_data_q;
   assign valid_o      = valid_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule
`default_nettype wire
